// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle HI/LO unit for a MIPS core: mult, multu, div, divu, mthi,
//   mtlo, mfhi, mflo. A radix-2 shift-add multiplier and a restoring divider
//   each run one iteration per cycle for DATA_W cycles. A final FIX cycle
//   applies sign correction and writes HI/LO.
//
//   Optional feature macro: MULDIV_EARLY_OUT_EN
//     defined   : MUL jumps to FIX as soon as the remaining multiplier bits
//                 are all zero (data-dependent latency, at least 2 busy cycles)
//     undefined : every mult/div takes DATA_W+1 busy cycles
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      decoded mult/div/mthi/mtlo present this cycle
//   op_muldiv  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6/7 no-op
//   src_a      rs value (dividend / multiplicand / mthi-mtlo data)
//   src_b      rt value (divisor / multiplier)
//   rd_req     mfhi/mflo present this cycle
//   rd_sel     0=LO, 1=HI
//   flush      abort in-flight operation, cancels a same-cycle start
//   busy       operation in flight (MUL, DIV or FIX)
//   stall      core must hold PC/instruction this cycle
//   rd_data    HI or LO selected by rd_sel, valid when stall=0
//   hi, lo     architectural HI/LO registers

module muldiv_sequencer #(
    parameter int DATA_W = 32,
    parameter int OP_BIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_BIT-1:0] op_muldiv,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              rd_req,
    input  logic              rd_sel,
    input  logic              flush,
    output logic              busy,
    output logic              stall,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    localparam logic [OP_BIT-1:0] OP_MULT  = OP_BIT'(0);
    localparam logic [OP_BIT-1:0] OP_MULTU = OP_BIT'(1);
    localparam logic [OP_BIT-1:0] OP_DIV   = OP_BIT'(2);
    localparam logic [OP_BIT-1:0] OP_DIVU  = OP_BIT'(3);
    localparam logic [OP_BIT-1:0] OP_MTHI  = OP_BIT'(4);
    localparam logic [OP_BIT-1:0] OP_MTLO  = OP_BIT'(5);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t state;
    state_t state_next;

    // Work registers
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] prod;      // running product
    logic [2*DATA_W-1:0] mcand;     // multiplicand, shifted left each step
    logic [DATA_W-1:0]   mplier;    // multiplier, shifted right each step
    logic [DATA_W-1:0]   rem;       // partial remainder
    logic [DATA_W-1:0]   quo;       // dividend shifting out / quotient shifting in
    logic [DATA_W-1:0]   dsor;      // divisor magnitude
    logic                neg_q;     // negate product or quotient in FIX
    logic                neg_r;     // negate remainder in FIX
    logic                div_zero;  // divisor was zero: force quotient to all ones
    logic                div_op;    // FIX writes divide results rather than product

    // Operand decode
    logic                is_mul;
    logic                is_div;
    logic                signed_op;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;

    assign is_mul    = (op_muldiv == OP_MULT) || (op_muldiv == OP_MULTU);
    assign is_div    = (op_muldiv == OP_DIV)  || (op_muldiv == OP_DIVU);
    assign signed_op = (op_muldiv == OP_MULT) || (op_muldiv == OP_DIV);
    assign a_neg     = signed_op & src_a[DATA_W-1];
    assign b_neg     = signed_op & src_b[DATA_W-1];
    assign a_mag     = a_neg ? -src_a : src_a;
    assign b_mag     = b_neg ? -src_b : src_b;

    // One multiply iteration
    logic [2*DATA_W-1:0] prod_step;
    logic [DATA_W-1:0]   mplier_step;

    assign prod_step   = mplier[0] ? (prod + mcand) : prod;
    assign mplier_step = mplier >> 1;

    // One restoring-divide iteration: the top bit of the difference is the
    // borrow, which is clear exactly when the shifted remainder >= divisor.
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W:0]     rem_diff;
    logic                rem_ge;

    assign rem_shift = {rem, quo[DATA_W-1]};
    assign rem_diff  = rem_shift - {1'b0, dsor};
    assign rem_ge    = ~rem_diff[DATA_W];

    // Sign correction applied during FIX. With a zero divisor the remainder
    // iterations leave |a| in rem, so neg_r restores the original src_a.
    logic [2*DATA_W-1:0] mul_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign mul_fix = neg_q ? -prod : prod;
    assign quo_fix = div_zero ? '1 : (neg_q ? -quo : quo);
    assign rem_fix = neg_r ? -rem : rem;

    logic mul_done;
`ifdef MULDIV_EARLY_OUT_EN
    assign mul_done = (count == '0) || (mplier_step == '0);
`else
    assign mul_done = (count == '0);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush wins over everything
    always_comb begin
        // NOTE: default assignment first so every path drives state_next and no latch is inferred.
        state_next = state;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && is_mul) begin
                        state_next = S_MUL;
                    end else if (start && is_div) begin
                        state_next = S_DIV;
                    end
                end
                S_MUL:   if (mul_done)      state_next = S_FIX;
                S_DIV:   if (count == '0)   state_next = S_FIX;
                S_FIX:   state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy    = (state != S_IDLE);
        stall   = busy & (start | rd_req);
        rd_data = rd_sel ? hi : lo;
    end

    // Datapath and HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            dsor     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            div_op   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (flush) begin
            // Abort: HI/LO keep their previous values
            count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            prod   <= '0;
                            mcand  <= {{DATA_W{1'b0}}, a_mag};
                            mplier <= b_mag;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= 1'b0;
                            div_op <= 1'b0;
                            count  <= LAST_CNT;
                        end else if (is_div) begin
                            rem      <= '0;
                            quo      <= a_mag;
                            dsor     <= b_mag;
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            div_zero <= (src_b == '0);
                            div_op   <= 1'b1;
                            count    <= LAST_CNT;
                        end else if (op_muldiv == OP_MTHI) begin
                            hi <= src_a;
                        end else if (op_muldiv == OP_MTLO) begin
                            lo <= src_a;
                        end
                    end
                end
                S_MUL: begin
                    prod   <= prod_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier_step;
                    count  <= count - CNT_W'(1);
                end
                S_DIV: begin
                    rem   <= rem_ge ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
                    quo   <= {quo[DATA_W-2:0], rem_ge};
                    count <= count - CNT_W'(1);
                end
                S_FIX: begin
                    if (div_op) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= mul_fix[2*DATA_W-1:DATA_W];
                        lo <= mul_fix[DATA_W-1:0];
                    end
                    count <= '0;
                end
                default: count <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Scoreboard bench for muldiv_sequencer. Expected HI/LO results and read
//   data come from an arithmetic reference model (64-bit products, native
//   signed/unsigned division); a monitor compares them whenever an operation
//   retires (busy falls) or a read is granted (rd_req with stall low).

module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op_muldiv = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        rd_req = 1'b0;
    logic        rd_sel = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        stall;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_sequencer #(.DATA_W(32), .OP_BIT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_muldiv (op_muldiv),
        .src_a     (src_a),
        .src_b     (src_b),
        .rd_req    (rd_req),
        .rd_sel    (rd_sel),
        .flush     (flush),
        .busy      (busy),
        .stall     (stall),
        .rd_data   (rd_data),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } res_t;

    typedef struct {
        logic [31:0] data;
        string       name;
    } rd_t;

    res_t res_q[$];
    rd_t  rd_q[$];

    // Architectural HI/LO as the reference model sees them
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural values
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic [63:0]     p;
        case (op)
            3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: begin
                if (b == 0) begin m_hi = a; m_lo = '1; end
                else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            end
            3'd3: begin
                if (b == 0) begin m_hi = a; m_lo = '1; end
                else begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Expected busy cycles for an accepted op
    function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
        logic [31:0] m;
        int          n;
        m = (op == 3'd0 && b[31]) ? -b : b;
        n = 0;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        if (op > 3'd3) return 0;
`ifdef MULDIV_EARLY_OUT_EN
        if (op <= 3'd1) return ((n == 0) ? 1 : n) + 1;
`endif
        return (n >= 0) ? 33 : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start until accepted; push the expected retirement result.
    // 'aborted' ops (flush/reset) leave the model untouched.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit aborted, input string name, output int stalled);
        res_t e;
        start = 1'b1; op_muldiv = op; src_a = a; src_b = b;
        stalled = 0;
        @(negedge clk);
        while (stall && stalled < 200) begin
            stalled++;
            @(negedge clk);
        end
        if (stall) check({name, " accept timeout"}, 1, 0);
        step();
        start = 1'b0;
        if (!aborted) model_op(op, a, b);
        if (op <= 3'd3) begin
            e.hi = m_hi; e.lo = m_lo; e.name = name;
            res_q.push_back(e);
        end
    endtask

    // Count busy cycles following acceptance
    task automatic wait_done(input int exp, input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({name, " busy cycles"}, n, exp);
        step();
    endtask

    // mfhi/mflo held until granted
    task automatic rd(input bit sel, input string name, output int stalled);
        rd_t r;
        rd_req = 1'b1; rd_sel = sel;
        r.data = sel ? m_hi : m_lo; r.name = name;
        rd_q.push_back(r);
        stalled = 0;
        @(negedge clk);
        while (stall && stalled < 200) begin
            stalled++;
            @(negedge clk);
        end
        step();
        rd_req = 1'b0;
    endtask

    // Monitor
    logic prev_busy = 1'b0;
    always @(negedge clk) begin : monitor
        res_t e;
        rd_t  r;
        if (rd_req && !stall) begin
            if (rd_q.size() == 0) begin
                check("unexpected read", 1, 0);
            end else begin
                r = rd_q.pop_front();
                check({r.name, " rd_data"}, rd_data, r.data);
            end
        end
        if (prev_busy && !busy) begin
            if (res_q.size() == 0) begin
                check("unexpected retire", 1, 0);
            end else begin
                e = res_q.pop_front();
                check({e.name, " hi"}, hi, e.hi);
                check({e.name, " lo"}, lo, e.lo);
            end
        end
        prev_busy = busy;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          st;
        int          st2;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset stall", stall, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        rst = 1'b0;
        step();

        // Signed multiply, negative result
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 0, "mult -2*3", st);
        wait_done(exp_busy(3'd0, 32'd3), "mult -2*3");

        // Unsigned multiply with an mflo arriving on cycle 5
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu max", st);
        fork
            wait_done(exp_busy(3'd1, 32'hFFFF_FFFF), "multu max");
            begin
                repeat (4) step();
                rd(1'b0, "mflo stalled", st2);
            end
        join
        check("mflo stall cycles", st2, 29);

        // Divides: signed, divide by zero
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 0, "div -7/2", st);
        wait_done(33, "div -7/2");
        issue(3'd3, 32'd100, 32'd0, 0, "divu 100/0", st);
        wait_done(33, "divu 100/0");

        // Overflow divide, with a second start presented back to back
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div min/-1", st);
        fork
            wait_done(33, "div min/-1");
            issue(3'd1, 32'd7, 32'd9, 0, "multu 7*9", st2);
        join
        check("b2b start stall cycles", st2, 33);
        wait_done(exp_busy(3'd1, 32'd9), "multu 7*9");

        // mthi then reads
        issue(3'd4, 32'h0000_1234, 32'd0, 0, "mthi", st);
        wait_done(0, "mthi");
        rd(1'b1, "mfhi after mthi", st);
        rd(1'b0, "mflo after mthi", st);

        // flush in IDLE cancels a simultaneous mtlo
        start = 1'b1; op_muldiv = 3'd5; src_a = 32'hDEAD_BEEF; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        rd(1'b0, "mflo after flushed mtlo", st);

        // Non-trivial HI/LO, then flush a MULT on its 10th cycle
        issue(3'd0, 32'h1234_5678, 32'hFFFF_9ABC, 0, "mult mixed", st);
        wait_done(exp_busy(3'd0, 32'hFFFF_9ABC), "mult mixed");
        issue(3'd0, 32'h0000_0077, 32'h8000_0001, 1, "mult flushed", st);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush busy", busy, 0);
        step();

        // Asynchronous reset in the middle of a DIV
        issue(3'd2, 32'h7654_3210, 32'd13, 1, "div reset", st);
        repeat (10) step();
        rst = 1'b1;
        #1;
        check("mid-op reset busy", busy, 0);
        check("mid-op reset hi", hi, 0);
        check("mid-op reset lo", lo, 0);
        res_q.delete();
        m_hi = '0; m_lo = '0;
        begin
            res_t z;
            z.hi = '0; z.lo = '0; z.name = "div reset";
            res_q.push_back(z);
        end
        step();
        rst = 1'b0;
        step();

        // Randomized ops against the model
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(0, 255));
                2:       b = -32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1000));
            issue(op, a, b, 0, $sformatf("rand%0d op%0d", i, op), st);
            wait_done(exp_busy(op, b), $sformatf("rand%0d op%0d", i, op));
            rd(1'($urandom_range(0, 1)), $sformatf("rand%0d read", i), st);
        end

        // Small multiplier (early-out candidate)
        issue(3'd0, 32'd5, 32'd1, 0, "mult 5*1", st);
        wait_done(exp_busy(3'd0, 32'd1), "mult 5*1");
        rd(1'b0, "mflo 5*1", st);

        check("scoreboard drained", res_q.size() + rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
